rr_mux_arbiter: RTL
===================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per owner (legal 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  8  per-requester request for the shared 32-bit 8:1 operand mux; bit i = requester i.
REQ-005 Port: grant  output  8  one-hot grant; all-zero when no owner.
REQ-006 Port: sel  output  3  mux select, binary index of current owner.
REQ-007 Port: busy  output  1  high while any grant bit is high.
REQ-008 Port: timeout  output  1  one-cycle pulse when an owner is forcibly released.

Function
REQ-009 FSM states SHALL be IDLE, GRANT and RELEASE, with all outputs registered.
REQ-010 In IDLE or RELEASE with req != 0, the winner SHALL be the first set req bit searching upward from (ptr+1) mod 8; next state GRANT.
REQ-011 In IDLE or RELEASE with req == 0, next state SHALL be IDLE.
REQ-012 Grant latency SHALL be exactly one cycle: req sampled at edge N, grant/sel/busy valid after edge N.
REQ-013 On entering GRANT, ptr SHALL load the winner index, sel SHALL equal the winner index, and grant SHALL equal 1<<winner.
REQ-014 In GRANT, the owner SHALL keep the grant while req[owner] = 1; requests from other requesters SHALL be ignored.
REQ-015 In GRANT, when req[owner] = 0 at an edge, next state SHALL be RELEASE with grant = 0 and busy = 0.
REQ-016 RELEASE SHALL last exactly one cycle as a mux turnaround; no two different owners are ever granted on adjacent cycles.
REQ-017 When no owner is granted, sel SHALL hold the last owner index.
REQ-018 The hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-019 Simultaneous owner drop and timeout SHALL be treated as a normal release, with timeout = 0.
REQ-020 Because ptr already holds the released owner, that owner SHALL have lowest priority in the next arbitration.

Reset
REQ-021 While rst_n = 0: state = IDLE, grant = 0, sel = 0, busy = 0, timeout = 0, ptr = 7, counter = 0, so requester 0 has first priority.
REQ-022 Reset assertion mid-GRANT SHALL drop grant asynchronously without passing through RELEASE.
REQ-023 The first arbitration SHALL happen at the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro RR_MUX_ARBITER_TIMEOUT_EN defined: when the counter reaches MAX_HOLD-1 with req[owner] still 1, next state SHALL be RELEASE and timeout SHALL pulse high for the RELEASE cycle.
REQ-025 Macro RR_MUX_ARBITER_TIMEOUT_EN undefined: the counter logic SHALL be absent, an owner SHALL hold indefinitely, and timeout SHALL be tied 0.

Structure
REQ-026 Package rr_mux_arbiter_pkg SHALL hold NUM_REQ = 8, SEL_W = 3 and the state enum type.
REQ-027 Round-robin search SHALL live in combinational sub-module rr_priority_pick: inputs req[7:0] and ptr[2:0]; outputs any and idx[2:0].

Verification
REQ-028 Reset release, req = 8'b0000_0001 at edge 1 -> grant = 01, sel = 0, busy = 1 after edge 1.
REQ-029 req = 8'hFF held, timeout compiled out, owner drops req each time after 3 granted cycles -> owners 0,1,2,...,7,0 in order, with one RELEASE cycle between owners.
REQ-030 Owner 5 granted, req[5] drops while req[2] = 1 -> one cycle grant = 0, then grant = 8'h04, sel = 2.
REQ-031 RR_MUX_ARBITER_TIMEOUT_EN defined, MAX_HOLD = 4, req[3] held high alone -> grant high for 4 cycles, timeout pulse, RELEASE, then owner 3 regranted.
REQ-032 Same setup with req[3] and req[6] held high -> after timeout, grant passes to 6, then back to 3.
REQ-033 rst_n pulsed low mid-GRANT of owner 4 -> grant = 0 and sel = 0 immediately; next grant favours requester 0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and sizes for the round-robin 8:1 operand mux arbiter.
// Requester count, select width and the arbiter state encoding.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin search: first set req bit scanning upward from ptr+1, wrapping.
// Purely combinational; ptr itself is the last candidate.
module rr_priority_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest priority (ptr) to the highest (ptr+1) so the last hit wins.
  always_comb begin
    idx  = ptr;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 operand mux; optional forced release under RR_MUX_ARBITER_TIMEOUT_EN.
// Latency: grant/sel/busy registered one cycle after req is sampled; one RELEASE turnaround cycle between owners.
// Backpressure: an owner keeps the mux while it requests; other requests wait until release (or timeout).
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  output logic                 timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_mux_arbiter: MAX_HOLD must be within 2..255");
  end

  state_t               state, state_n;
  logic [SEL_W-1:0]     ptr, ptr_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic [SEL_W-1:0]     sel_n;
  logic                 busy_n;
  logic                 pick_any;
  logic [SEL_W-1:0]     pick_idx;

`ifdef RR_MUX_ARBITER_TIMEOUT_EN
  logic [7:0]           hold_cnt, hold_cnt_n;
  logic                 timeout_q, timeout_n;
  logic                 hold_last;

  assign hold_last = (hold_cnt == 8'(MAX_HOLD - 1));
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    sel_n   = sel;
    busy_n  = busy;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;
`endif
    case (state)
      IDLE, RELEASE: begin
        if (pick_any) begin
          state_n = GRANT;
          ptr_n   = pick_idx;
          sel_n   = pick_idx;
          grant_n = onehot(pick_idx);
          busy_n  = 1'b1;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end else begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
        end
      end
      GRANT: begin
        // ptr always names the current owner while in GRANT.
        if (!req[ptr]) begin
          state_n = RELEASE;
          grant_n = '0;
          busy_n  = 1'b0;
        end
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
        else if (hold_last) begin
          state_n   = RELEASE;
          grant_n   = '0;
          busy_n    = 1'b0;
          timeout_n = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // ptr resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= SEL_W'(NUM_REQ - 1);
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      grant <= grant_n;
      sel   <= sel_n;
      busy  <= busy_n;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      hold_cnt  <= hold_cnt_n;
      timeout_q <= timeout_n;
`endif
    end
  end

endmodule
